// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search block: FSM states and
// the comparator flag decode.
package sar_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SEARCH = 1'b1
  } sar_state_e;

  typedef enum logic [1:0] {
    DEC_KEEP   = 2'd0,
    DEC_LARGER = 2'd1,
    DEC_EQUAL  = 2'd2
  } sar_dec_e;

  // Equal wins over larger; "smaller" and "no flag" both mean keep the trial bit.
  function automatic sar_dec_e decode_flags(input logic eq, input logic lg);
    if (eq)      return DEC_EQUAL;
    else if (lg) return DEC_LARGER;
    else         return DEC_KEEP;
  endfunction

endpackage

// File: rtl/sar_search.sv
// MSB-first binary search driving an external comparator; settles on the
// largest value not above the target, terminating early on an exact match.
//
// Handshake: the candidate is held stable while cmp_valid=0; the three flags
// are consumed only on a rising edge where the FSM is in SEARCH and
// cmp_valid=1. There is no timeout.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] candidate,
  input  logic             cmp_valid,
  input  logic             cand_smaller,
  input  logic             cand_equal,
  input  logic             cand_larger,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output sar_state_e       state_dbg
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0]    TOP_IDX = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  sar_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] work_nxt;
  sar_dec_e         dec;

  // "smaller" carries no extra information once equal and larger are known.
  logic unused_smaller;
  assign unused_smaller = cand_smaller;

  assign dec = decode_flags(cand_equal, cand_larger);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    work_d   = work_q;
    cand_d   = cand_q;
    result_d = result_q;
    found_d  = found_q;
    done_d   = 1'b0;
    work_nxt = work_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEARCH;
          idx_d   = TOP_IDX;
          work_d  = '0;
          cand_d  = ONE << TOP_IDX;
          found_d = 1'b0;
        end
      end
      S_SEARCH: begin
        if (cmp_valid) begin
          if (dec == DEC_EQUAL) begin
            result_d = cand_q;
            found_d  = 1'b1;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            work_nxt = (dec == DEC_KEEP) ? (work_q | (ONE << idx_q)) : work_q;
            work_d   = work_nxt;
            if (idx_q == '0) begin
              // Candidate mirrors result in IDLE, so both take the final value.
              result_d = work_nxt;
              cand_d   = work_nxt;
              found_d  = 1'b0;
              done_d   = 1'b1;
              state_d  = S_IDLE;
            end else begin
              idx_d  = idx_q - 1'b1;
              cand_d = work_nxt | (ONE << (idx_q - 1'b1));
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      work_q   <= '0;
      cand_q   <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      work_q   <= work_d;
      cand_q   <= cand_d;
      result_q <= result_d;
      found_q  <= found_d;
      done_q   <= done_d;
    end
  end

  assign candidate = cand_q;
  assign busy      = (state_q == S_SEARCH);
  assign done      = done_q;
  assign result    = result_q;
  assign found     = found_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a behavioural target comparator plus a reference
// model that predicts each search from the target value alone.
module tb_sar_search;
  import sar_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         cmp_valid = 1'b0;
  logic         cand_smaller, cand_equal, cand_larger;
  logic [W-1:0] candidate, result;
  logic         busy, done, found;
  sar_state_e   state_dbg;

  logic [W-1:0] target = '0;
  logic         no_equal = 1'b0;
  logic [2:0]   junk = '0;

  sar_search #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .candidate    (candidate),
    .cmp_valid    (cmp_valid),
    .cand_smaller (cand_smaller),
    .cand_equal   (cand_equal),
    .cand_larger  (cand_larger),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .found        (found),
    .state_dbg    (state_dbg)
  );

  // Target comparator; flags are garbage whenever cmp_valid is low.
  always_comb begin
    cand_equal   = 1'b0;
    cand_larger  = 1'b0;
    cand_smaller = 1'b0;
    if (cmp_valid) begin
      cand_equal   = !no_equal && (candidate == target);
      cand_larger  = candidate > target;
      cand_smaller = candidate < target;
    end else begin
      {cand_equal, cand_larger, cand_smaller} = junk;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_res = '0;
  logic         exp_fnd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the search lands on the target itself. An equal flag ends it at
  // the compare whose trial bit is the target's lowest set bit.
  task automatic model(input logic [W-1:0] tgt, input logic noeq,
                       output int k, output logic fnd);
    int tz;
    tz = 0;
    while (tz < W && tgt[tz] == 1'b0) tz++;
    if (noeq || tgt == '0) begin
      k = W;
      fnd = 1'b0;
    end else begin
      k = W - tz;
      fnd = 1'b1;
    end
    exp_q.delete();
    for (int j = 0; j < k; j++) begin
      int hi;
      hi = (int'(tgt) >> (W - j)) << (W - j);
      exp_q.push_back(W'(hi | (1 << (W - 1 - j))));
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic do_search(input logic [W-1:0] tgt, input logic noeq,
                           input int smin, input int smax, input logic poke);
    int k;
    logic fnd;
    logic [W-1:0] ec;
    model(tgt, noeq, k, fnd);
    target = tgt;
    no_equal = noeq;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < k; j++) begin
      int n;
      ec = exp_q.pop_front();
      n = $urandom_range(smax, smin);
      for (int s = 0; s <= n; s++) begin
        chk("candidate", 32'(candidate), 32'(ec));
        chk("busy", 32'(busy), 32'd1);
        chk("done_low", 32'(done), 32'd0);
        chk("state", 32'(state_dbg), 32'(S_SEARCH));
        cmp_valid = (s == n);
        junk = 3'($urandom);
        start = poke ? 1'($urandom_range(1, 0)) : 1'b0;
        @(negedge clk);
      end
    end
    cmp_valid = 1'b0;
    start = 1'b0;
    exp_res = tgt;
    exp_fnd = fnd;
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("result", 32'(result), 32'(exp_res));
    chk("found", 32'(found), 32'(exp_fnd));
    chk("cand_idle", 32'(candidate), 32'(exp_res));
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      cmp_valid = 1'($urandom_range(1, 0));
      junk = 3'($urandom);
      @(negedge clk);
      chk("q_done", 32'(done), 32'd0);
      chk("q_busy", 32'(busy), 32'd0);
      chk("q_result", 32'(result), 32'(exp_res));
      chk("q_found", 32'(found), 32'(exp_fnd));
      chk("q_cand", 32'(candidate), 32'(exp_res));
    end
    cmp_valid = 1'b0;
  endtask

  // Abort a full-length search with reset during its 4th compare, while start
  // and cmp_valid are also high.
  task automatic reset_abort(input logic [W-1:0] tgt);
    int k;
    logic fnd;
    model(tgt | W'(1), 1'b0, k, fnd);
    target = tgt | W'(1);
    no_equal = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("ra_cand", 32'(candidate), 32'(exp_q.pop_front()));
      cmp_valid = 1'b1;
      @(negedge clk);
    end
    chk("ra_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    cmp_valid = 1'b0;
    exp_res = '0;
    exp_fnd = 1'b0;
    chk("ra_done", 32'(done), 32'd0);
    chk("ra_busy0", 32'(busy), 32'd0);
    chk("ra_result", 32'(result), 32'd0);
    chk("ra_found", 32'(found), 32'd0);
    chk("ra_cand0", 32'(candidate), 32'd0);
    quiet(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_cand", 32'(candidate), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    quiet(2);

    do_search(8'h5A, 1'b0, 0, 0, 1'b0);
    quiet(2);
    do_search(8'h00, 1'b0, 0, 0, 1'b0);
    quiet(1);
    do_search(8'hFF, 1'b1, 0, 0, 1'b0);
    quiet(1);
    do_search(8'h80, 1'b0, 0, 0, 1'b0);
    quiet(1);
    do_search(8'h33, 1'b0, 3, 3, 1'b0);
    quiet(2);
    do_search(8'hC6, 1'b0, 0, 1, 1'b1);
    quiet(1);
    reset_abort(8'h9C);
    do_search(8'h41, 1'b0, 0, 0, 1'b0);
    do_search(8'h17, 1'b0, 0, 0, 1'b0);
    quiet(1);

    for (int i = 0; i < 40; i++) begin
      do_search(W'($urandom), ($urandom_range(3, 0) == 0), 0, 2, 1'($urandom_range(1, 0)));
      if ($urandom_range(1, 0) == 1) quiet($urandom_range(3, 1));
    end
    quiet(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
